mul_seq_ctrl: RTL and testbench
===============================

// Module: mul_seq_ctrl
// PURPOSE
//  Multi-cycle unsigned shift-and-add multiplier sequencer for the RV32 execute stage.
//  Owns no adder: drives one shared 32-bit ripple-carry adder instance (A/B/carry-in -> sum/carry-out) once per cycle.
//  Serves MUL (low 32 bits of product) and MULHU (high 32 bits) through valid/ready request and response handshakes.
//  Signed high-half variants are out of scope; they are handled upstream.
// PARAMETERS
//  XLEN       32  operand/result width; iteration counter is $clog2(XLEN) bits
//  ZERO_SKIP  0   1: an op_a==0 or op_b==0 request completes without iterating
// PORTS
//  clk        in   1     system clock, all state updates on rising edge
//  rst_n      in   1     synchronous active-low reset
//  req_valid  in   1     request present
//  req_ready  out  1     block can accept (state IDLE)
//  req_hi     in   1     0: MUL (product[31:0]), 1: MULHU (product[63:32])
//  op_a       in   XLEN  multiplicand
//  op_b       in   XLEN  multiplier
//  kill       in   1     pipeline flush; abandon current op
//  resp_valid out  1     result valid
//  resp_ready in   1     consumer accepts result
//  resp_data  out  XLEN  selected product half
//  add_a      out  XLEN  to shared adder A
//  add_b      out  XLEN  to shared adder B
//  add_cin    out  1     to shared adder carry-in, tied 0
//  add_sum    in   XLEN  from shared adder sum
//  add_cout   in   1     from shared adder carry-out
// BEHAVIOUR
//  Reset (edge with rst_n=0): state IDLE, count=0, hi/lo/mcand/sel_hi=0, resp_valid=0, resp_data=0. Reset overrides kill and any handshake.
//  States IDLE -> CALC -> DONE -> IDLE.
//  IDLE: req_ready=1. On req_valid&req_ready: mcand<=op_a, lo<=op_b, hi<=0, sel_hi<=req_hi, count<=0, go CALC.
//   With ZERO_SKIP=1 and op_a==0 or op_b==0: hi,lo<=0 and go straight to DONE.
//  CALC: req_ready=0. add_a=hi, add_b = lo[0] ? mcand : 0, add_cin=0. Each edge:
//   hi <= {add_cout, add_sum[XLEN-1:1]}; lo <= {add_sum[0], lo[XLEN-1:1]}; count<=count+1.
//   After the edge where count==XLEN-1 (XLEN iterations), go DONE. Counter wrap is never observed.
//  DONE: resp_valid=1, resp_data = sel_hi ? hi : lo (registered, stable while held).
//   On resp_ready go IDLE; resp_valid drops the next cycle. Held indefinitely while resp_ready=0.
//  Adder drive outside CALC: add_a=add_b=0.
//  Latency: with resp_ready=1, resp_valid is high XLEN cycles after the accepting edge, or 1 cycle with zero skip.
//   Throughput: one op per XLEN+2 cycles. No request is accepted in the DONE cycle, even while resp_ready=1.
//  kill, any state but reset: next state IDLE, resp_valid=0, no response for the killed op.
//   A req_valid in the same cycle as kill is not accepted.
//  Product is exact 2*XLEN unsigned; carry-out of each add is never dropped (becomes hi MSB).
// TESTING
//  1. MUL 3*5, resp_ready=1 -> resp_data=0x0000000F; resp_valid rises exactly 32 cycles after accept; req_ready=0 meanwhile.
//  2. 0xFFFFFFFF*0xFFFFFFFF -> MULHU resp 0xFFFFFFFE, MUL resp 0x00000001; add_cout seen =1 in CALC.
//  3. MULHU 0x80000000*0x00000002 -> 0x00000001; MUL same operands -> 0x00000000.
//  4. resp_ready=0 for 10 cycles after done -> resp_valid and resp_data (0x0000000F) stable; req_ready stays 0.
//  5. kill at iteration 10 -> resp_valid never rises, req_ready=1 next cycle; following MUL 7*6 -> 0x0000002A.
//  6. rst_n=0 mid-CALC -> next cycle IDLE, resp_valid=0. ZERO_SKIP=1, op_b=0 -> resp_data=0 one cycle after accept.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - sequential shift-and-add multiplier sequencer driving a shared adder
//
// Computes the exact 2*XLEN-bit unsigned product of op_a and op_b, one
// partial-product add per cycle, using an adder that lives outside this block.
// Returns the low half (MUL) or the high half (MULHU) of the product.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   req_valid/req_ready     request handshake; req_hi selects the high half
//   op_a, op_b              multiplicand, multiplier
//   kill                    pipeline flush, abandons the current operation
//   resp_valid/resp_ready   response handshake; resp_data is the selected half
//   add_a/add_b/add_cin     operands driven to the shared adder
//   add_sum/add_cout        result returned by the shared adder

module mul_seq_ctrl #(
    parameter int XLEN      = 32,
    parameter bit ZERO_SKIP = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_hi,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [XLEN-1:0] add_a,
    output logic [XLEN-1:0] add_b,
    output logic            add_cin,
    input  logic [XLEN-1:0] add_sum,
    input  logic            add_cout
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q,      state_d;
    logic [CW-1:0]   count_q,      count_d;
    logic [XLEN-1:0] hi_q,         hi_d;
    logic [XLEN-1:0] lo_q,         lo_d;
    logic [XLEN-1:0] mcand_q,      mcand_d;
    logic            sel_hi_q,     sel_hi_d;
    logic            resp_valid_q, resp_valid_d;
    logic [XLEN-1:0] resp_data_q,  resp_data_d;

    logic            zero_op;

    assign zero_op    = (op_a == '0) || (op_b == '0);
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign add_cin    = 1'b0;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        mcand_d      = mcand_q;
        sel_hi_d     = sel_hi_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        add_a        = '0;
        add_b        = '0;

        case (state_q)
            ST_IDLE: begin
                // A request presented together with kill is dropped.
                if (req_valid && !kill) begin
                    mcand_d  = op_a;
                    lo_d     = op_b;
                    hi_d     = '0;
                    sel_hi_d = req_hi;
                    count_d  = '0;
                    state_d  = ST_CALC;
                    if (ZERO_SKIP && zero_op) begin
                        lo_d         = '0;
                        state_d      = ST_DONE;
                        resp_valid_d = 1'b1;
                        resp_data_d  = '0;
                    end
                end
            end

            ST_CALC: begin
                add_a = hi_q;
                add_b = lo_q[0] ? mcand_q : '0;
                // {hi,lo} shifts right by one with the sum on top; the adder
                // carry-out becomes the new hi MSB so no product bit is lost.
                hi_d    = {add_cout, add_sum[XLEN-1:1]};
                lo_d    = {add_sum[0], lo_q[XLEN-1:1]};
                count_d = count_q + CW'(1);
                if (count_q == LAST_ITER) begin
                    state_d      = ST_DONE;
                    resp_valid_d = 1'b1;
                    resp_data_d  = sel_hi_q ? hi_d : lo_d;
                end
            end

            ST_DONE: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                end
            end

            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
            end
        endcase

        // Flush wins over every handshake in the same cycle.
        if (kill) begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            mcand_q      <= '0;
            sel_hi_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            mcand_q      <= mcand_d;
            sel_hi_q     <= sel_hi_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - self-checking bench for mul_seq_ctrl with an arithmetic product model

module tb_mul_seq_ctrl;

    logic        clk;
    logic        rst_n;

    // Default instance (ZERO_SKIP=0)
    logic        req_valid, req_ready, req_hi, kill;
    logic [31:0] op_a, op_b;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic [31:0] add_a, add_b, add_sum;
    logic        add_cin, add_cout;

    // Zero-skip instance
    logic        z_req_valid, z_req_ready, z_req_hi, z_kill;
    logic [31:0] z_op_a, z_op_b;
    logic        z_resp_valid, z_resp_ready;
    logic [31:0] z_resp_data;
    logic [31:0] z_add_a, z_add_b, z_add_sum;
    logic        z_add_cin, z_add_cout;

    int checks;
    int failures;

    // Shared ripple-carry adders modelled behaviourally
    assign {add_cout, add_sum}     = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};
    assign {z_add_cout, z_add_sum} = {1'b0, z_add_a} + {1'b0, z_add_b} + {32'b0, z_add_cin};

    mul_seq_ctrl #(.XLEN(32), .ZERO_SKIP(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_hi(req_hi),
        .op_a(op_a), .op_b(op_b), .kill(kill),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    mul_seq_ctrl #(.XLEN(32), .ZERO_SKIP(1'b1)) u_zs (
        .clk(clk), .rst_n(rst_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_hi(z_req_hi),
        .op_a(z_op_a), .op_b(z_op_b), .kill(z_kill),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready), .resp_data(z_resp_data),
        .add_a(z_add_a), .add_b(z_add_b), .add_cin(z_add_cin),
        .add_sum(z_add_sum), .add_cout(z_add_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic hi);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        return hi ? p[63:32] : p[31:0];
    endfunction

    // Issue one op on the default instance; returns the result seen when
    // resp_valid first rises, the number of edges after the accepting edge,
    // how often req_ready was seen high while waiting, and whether the adder
    // produced a carry-out during the calculation.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic hi,
                          input logic rr, output logic [31:0] data, output int lat,
                          output int rdy_hi, output logic cout_seen);
        int g;
        @(negedge clk);
        op_a = a; op_b = b; req_hi = hi; req_valid = 1'b1; resp_ready = rr;
        g = 0;
        while (!req_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0; rdy_hi = 0; cout_seen = 1'b0;
        while (!resp_valid && lat < 100) begin
            if (req_ready) rdy_hi++;
            if (add_cout) cout_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        data = resp_data;
    endtask

    task automatic test_reset();
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b valid=%b data=%h required 1 0 00000000",
                     req_ready, resp_valid, resp_data);
        end
        checks++;
        if (add_a !== 32'h0 || add_b !== 32'h0 || add_cin !== 1'b0) begin
            failures++;
            $display("FAIL reset_adder: a=%h b=%h cin=%b required zeros", add_a, add_b, add_cin);
        end
        checks++;
        if (z_req_ready !== 1'b1 || z_resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_zs: ready=%b valid=%b required 1 0", z_req_ready, z_resp_valid);
        end
    endtask

    task automatic test_mul_basic();
        logic [31:0] d; int lat, rh; logic cs;
        run_op(32'd3, 32'd5, 1'b0, 1'b1, d, lat, rh, cs);
        checks++;
        if (d !== 32'h0000000F) begin
            failures++; $display("FAIL mul_3x5: got %h required 0000000f", d);
        end
        checks++;
        if (lat !== 32) begin
            failures++; $display("FAIL latency_3x5: got %0d required 32", lat);
        end
        checks++;
        if (rh !== 0) begin
            failures++; $display("FAIL ready_during_calc: high %0d cycles required 0", rh);
        end
    endtask

    task automatic test_all_ones();
        logic [31:0] d; int lat, rh; logic cs;
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, d, lat, rh, cs);
        checks++;
        if (d !== 32'hFFFFFFFE) begin
            failures++; $display("FAIL mulhu_ones: got %h required fffffffe", d);
        end
        checks++;
        if (cs !== 1'b1) begin
            failures++; $display("FAIL cout_seen: got %b required 1", cs);
        end
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, d, lat, rh, cs);
        checks++;
        if (d !== 32'h00000001) begin
            failures++; $display("FAIL mul_ones: got %h required 00000001", d);
        end
    endtask

    task automatic test_msb();
        logic [31:0] d; int lat, rh; logic cs;
        run_op(32'h80000000, 32'h00000002, 1'b1, 1'b1, d, lat, rh, cs);
        checks++;
        if (d !== 32'h00000001) begin
            failures++; $display("FAIL mulhu_msb: got %h required 00000001", d);
        end
        run_op(32'h80000000, 32'h00000002, 1'b0, 1'b1, d, lat, rh, cs);
        checks++;
        if (d !== 32'h00000000) begin
            failures++; $display("FAIL mul_msb: got %h required 00000000", d);
        end
    endtask

    task automatic test_hold();
        logic [31:0] d; int lat, rh; logic cs; int bad;
        run_op(32'd3, 32'd5, 1'b0, 1'b0, d, lat, rh, cs);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (resp_valid !== 1'b1 || resp_data !== 32'h0000000F || req_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL hold_stable: %0d unstable cycles required 0 (valid=%b data=%h ready=%b)",
                     bad, resp_valid, resp_data, req_ready);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_release: valid=%b ready=%b required 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_kill();
        logic [31:0] d; int lat, rh; logic cs; int seen;
        @(negedge clk);
        op_a = 32'd7; op_b = 32'd6; req_hi = 1'b0; req_valid = 1'b1; kill = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL kill_blocks_accept: ready=%b required 1", req_ready);
        end
        kill = 1'b0;
        @(negedge clk);  // accepted on this edge
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL kill_idle: ready=%b valid=%b required 1 0", req_ready, resp_valid);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin
            failures++; $display("FAIL kill_no_resp: valid seen %0d cycles required 0", seen);
        end
        run_op(32'd7, 32'd6, 1'b0, 1'b1, d, lat, rh, cs);
        checks++;
        if (d !== 32'h0000002A || lat !== 32) begin
            failures++; $display("FAIL mul_after_kill: got %h lat %0d required 0000002a lat 32", d, lat);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        op_a = 32'h1234; op_b = 32'h5678; req_hi = 1'b0; req_valid = 1'b1; resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 32'h0 || add_a !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_calc: ready=%b valid=%b data=%h add_a=%h required 1 0 0 0",
                     req_ready, resp_valid, resp_data, add_a);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, d, e; logic hi; int lat, rh; logic cs; int bad;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            a = $urandom; b = $urandom; hi = 1'($urandom_range(0, 1));
            if (i == 3) a = 32'h0;
            if (i == 7) b = 32'h0;
            if (i == 9) b = 32'h1;
            e = ref_mul(a, b, hi);
            run_op(a, b, hi, 1'b1, d, lat, rh, cs);
            if (d !== e || lat !== 32 || rh !== 0) begin
                bad++;
                $display("FAIL random_op: a=%h b=%h hi=%b got %h lat %0d required %h lat 32",
                         a, b, hi, d, lat, e);
            end
        end
        checks++;
        if (bad !== 0) failures++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] expq[$];
        int acc_at[$];
        int accepted, responses, cyc, bad;
        logic adv;
        logic [31:0] e;
        accepted = 0; responses = 0; bad = 0; adv = 1'b0;
        @(negedge clk);
        op_a = $urandom; op_b = $urandom; req_hi = 1'($urandom_range(0, 1));
        req_valid = 1'b1; resp_ready = 1'b1;
        for (cyc = 0; cyc < 400 && responses < 4; cyc++) begin
            if (resp_valid) begin
                e = (expq.size() > 0) ? expq.pop_front() : 32'hDEADBEEF;
                if (resp_data !== e) begin
                    bad++;
                    $display("FAIL b2b_data: got %h required %h", resp_data, e);
                end
                responses++;
            end
            if (req_ready && req_valid) begin
                expq.push_back(ref_mul(op_a, op_b, req_hi));
                acc_at.push_back(cyc);
                accepted++;
                adv = 1'b1;
            end else if (adv) begin
                adv = 1'b0;
                if (accepted >= 4) req_valid = 1'b0;
                op_a = $urandom; op_b = $urandom; req_hi = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++;
        if (responses !== 4 || bad !== 0) begin
            failures++;
            $display("FAIL b2b_responses: got %0d responses %0d bad required 4 0", responses, bad);
        end
        checks++;
        if (acc_at.size() !== 4 || acc_at[1] - acc_at[0] !== 34 || acc_at[3] - acc_at[2] !== 34) begin
            failures++;
            $display("FAIL b2b_period: accepts=%0d period=%0d required 4 34", acc_at.size(),
                     (acc_at.size() > 1) ? acc_at[1] - acc_at[0] : -1);
        end
    endtask

    task automatic test_zero_skip();
        int lat;
        // op_b == 0, MUL
        @(negedge clk);
        z_op_a = $urandom | 32'h1; z_op_b = 32'h0; z_req_hi = 1'b0;
        z_req_valid = 1'b1; z_resp_ready = 1'b1;
        @(negedge clk);
        z_req_valid = 1'b0;
        checks++;
        if (z_resp_valid !== 1'b1 || z_resp_data !== 32'h0) begin
            failures++;
            $display("FAIL zs_opb_zero: valid=%b data=%h required 1 00000000", z_resp_valid, z_resp_data);
        end
        // op_a == 0, MULHU
        @(negedge clk);
        z_op_a = 32'h0; z_op_b = 32'hFFFFFFFF; z_req_hi = 1'b1; z_req_valid = 1'b1;
        @(negedge clk);
        z_req_valid = 1'b0;
        checks++;
        if (z_resp_valid !== 1'b1 || z_resp_data !== 32'h0) begin
            failures++;
            $display("FAIL zs_opa_zero: valid=%b data=%h required 1 00000000", z_resp_valid, z_resp_data);
        end
        // Nonzero operands still iterate the full length
        @(negedge clk);
        z_op_a = 32'd9; z_op_b = 32'd9; z_req_hi = 1'b0; z_req_valid = 1'b1;
        @(negedge clk);
        z_req_valid = 1'b0;
        lat = 0;
        while (!z_resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (z_resp_data !== 32'd81 || lat !== 32) begin
            failures++;
            $display("FAIL zs_nonzero: got %h lat %0d required 00000051 lat 32", z_resp_data, lat);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        req_valid = 1'b0; req_hi = 1'b0; op_a = '0; op_b = '0; kill = 1'b0; resp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_hi = 1'b0; z_op_a = '0; z_op_b = '0; z_kill = 1'b0;
        z_resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_mul_basic();
        test_all_ones();
        test_msb();
        test_hold();
        test_kill();
        test_reset_mid();
        test_random();
        test_back_to_back();
        test_zero_skip();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
